regbank_axil_arbiter: RTL and testbench
=======================================

// Module: regbank_axil_arbiter
// PURPOSE
//  Shares the single AXI4-Lite slave port (S00_AXI) of the register_bank IP between NUM_REQ
//  local requesters. Round-robin arbitrates simple single-word read/write requests, runs one
//  AXI4-Lite transaction at a time as bus master, and returns read data and response to the
//  granted requester. Sits between control logic (FSMs, DMA config) and the register bank.
// PARAMETERS
//  NUM_REQ     2   number of requesters (1..8)
//  ADDR_WIDTH  4   AXI address width (register bank: 4 x 32-bit regs, byte addr 0x0..0xC)
//  DATA_WIDTH  32  AXI data width (fixed 32; WSTRB width = DATA_WIDTH/8)
// PORTS
//  ACLK          in   1                     clock, all logic on rising edge
//  ARESET        in   1                     synchronous reset, active-high
//  req_valid     in   NUM_REQ               per-requester request; held until req_ready
//  req_write     in   NUM_REQ               1 = write, 0 = read
//  req_addr      in   NUM_REQ*ADDR_WIDTH    per-requester byte address (slice i = requester i)
//  req_wdata     in   NUM_REQ*DATA_WIDTH    per-requester write data
//  req_wstrb     in   NUM_REQ*DATA_WIDTH/8  per-requester byte strobes
//  req_ready     out  NUM_REQ               one-hot 1-cycle pulse: request accepted (granted)
//  rsp_valid     out  NUM_REQ               one-hot 1-cycle pulse: transaction complete
//  rsp_rdata     out  DATA_WIDTH            read data, valid with rsp_valid (0 for writes)
//  rsp_resp      out  2                     BRESP/RRESP of completed transaction
//  M_AXI_AWADDR/AWPROT/AWVALID out, AWREADY in   write address channel (AWPROT = 3'b000)
//  M_AXI_WDATA/WSTRB/WVALID out, WREADY in        write data channel
//  M_AXI_BRESP/BVALID in, BREADY out               write response channel
//  M_AXI_ARADDR/ARPROT/ARVALID out, ARREADY in   read address channel (ARPROT = 3'b000)
//  M_AXI_RDATA/RRESP/RVALID in, RREADY out        read data channel
// BEHAVIOUR
//  Reset: state=IDLE; all VALID/READY outputs, req_ready, rsp_valid = 0; rsp_rdata, rsp_resp,
//   AXI addr/data regs = 0; rr pointer = NUM_REQ-1 (so requester 0 has first priority).
//  All outputs registered. FSM: IDLE, WADDR, WRESP, RADDR, RDATA, RESP.
//  IDLE: if any req_valid, pick first set bit searching from ptr+1 (mod NUM_REQ); pulse its
//   req_ready, latch addr/wdata/wstrb/write/id, ptr<=id; next = WADDR (write) or RADDR (read).
//   No req_valid -> stay IDLE, no pulse.
//  WADDR: AWVALID and WVALID asserted together from entry; each deasserts independently on
//   its own handshake (AWREADY / WREADY may come in either order or same cycle). Both done
//   -> WRESP. VALID never drops before its handshake; addr/data stable while VALID.
//  WRESP: BREADY=1; on BVALID capture BRESP, rsp_rdata<=0 -> RESP.
//  RADDR: ARVALID=1 until ARREADY -> RDATA. RDATA: RREADY=1; on RVALID capture RDATA,
//   RRESP -> RESP.
//  RESP: rsp_valid[id]=1 for exactly one cycle with rsp_rdata/rsp_resp; next IDLE. rsp_rdata
//   and rsp_resp hold until next completion.
//  Latency, zero-wait slave: write = req_ready cycle T, AW/W handshake T+1, B T+2, rsp_valid
//   T+3; read identical. Back-to-back: next grant earliest T+4.
//  One outstanding transaction max; requests arriving mid-transaction wait (not dropped).
//  Fairness: with all requesters continuously valid, grants rotate 0,1,..,N-1,0..
//  SLVERR/DECERR passed through in rsp_resp; no retry. No timeout (slave must respond).
//  Reset mid-transaction: immediate return to IDLE, all VALIDs low next cycle; in-flight
//   request lost, no rsp_valid. Slave reset together with this block (same ARESET domain).
//  Deasserting req_valid before req_ready is illegal (assertion in bench).
// TESTING
//  1 Req0 writes 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, then reads back -> rdata 0x1..0x4,
//    rsp_resp=0, rsp_valid[0] 3 cycles after each req_ready (zero-wait slave).
//  2 Req0 and req1 valid same cycle after reset (req0 wr 0xA5A5A5A5@0x0, req1 wr
//    0x5A5A5A5A@0x4) -> req0 granted first, then req1; readback matches.
//  3 Both requesters continuously valid, 8 transactions -> grant order 0,1,0,1,0,1,0,1.
//  4 Slave AWREADY delayed 3 cycles, WREADY immediate (and reverse) -> AW/W each held until
//    own handshake, single B, correct data written; WSTRB=4'b0011 writes 0xFFFFFFFF over
//    0x12345678 -> readback 0x1234FFFF.
//  5 Slave returns RRESP=2'b10 -> rsp_resp=2'b10 with rsp_valid; arbiter continues normally.
//  6 ARESET asserted in WRESP -> next cycle IDLE, all VALID/READY low, no rsp_valid; new
//    request after reset completes correctly.

Source files
------------

// File: rtl/regbank_axil_arbiter.sv
// Round-robin arbiter that shares one AXI4-Lite master port among NUM_REQ local requesters.
// It runs one single-word read or write at a time and returns the response to the granted requester.
module regbank_axil_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0]              req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_wstrb,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]           rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic [ADDR_WIDTH-1:0]           M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]           M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0]         M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0]           M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0]           M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY,
  output logic [2:0]                      o_dbg_state
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SW  = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WADDR = 3'd1,
    S_WRESP = 3'd2,
    S_RADDR = 3'd3,
    S_RDATA = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [IDW-1:0]        r_ptr, r_id, w_gid, w_cand;
  logic                  w_any, w_sel_write, w_aw_ok, w_w_ok;
  logic [ADDR_WIDTH-1:0] w_sel_addr, r_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata, r_wdata, r_cap_data, r_rsp_rdata;
  logic [SW-1:0]         w_sel_wstrb, r_wstrb;
  logic [1:0]            r_cap_resp, r_rsp_resp;
  logic                  r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
  logic [NUM_REQ-1:0]    r_req_ready, r_rsp_valid;

  // Search starts one past the last grant, so a requester that was just served goes last.
  always_comb begin
    w_any  = 1'b0;
    w_gid  = r_ptr;
    w_cand = r_ptr;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = IDW'((int'(r_ptr) + k) % NUM_REQ);
      if (!w_any && req_valid[w_cand]) begin
        w_any = 1'b1;
        w_gid = w_cand;
      end
    end
  end

  always_comb begin
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_wstrb = '0;
    w_sel_write = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gid == IDW'(i)) begin
        w_sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        w_sel_wstrb = req_wstrb[i*SW +: SW];
        w_sel_write = req_write[i];
      end
    end
  end

  // A cleared VALID inside WADDR means that channel has already handshaked.
  assign w_aw_ok = !r_awvalid || M_AXI_AWREADY;
  assign w_w_ok  = !r_wvalid  || M_AXI_WREADY;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_state_nxt = w_sel_write ? S_WADDR : S_RADDR;
      S_WADDR: if (w_aw_ok && w_w_ok) w_state_nxt = S_WRESP;
      S_WRESP: if (M_AXI_BVALID) w_state_nxt = S_RESP;
      S_RADDR: if (M_AXI_ARREADY) w_state_nxt = S_RDATA;
      S_RDATA: if (M_AXI_RVALID) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_ptr       <= IDW'(NUM_REQ - 1);
      r_id        <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_cap_data  <= '0;
      r_cap_resp  <= '0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= '0;
      r_req_ready <= '0;
      r_rsp_valid <= '0;
    end else begin
      r_req_ready <= '0;
      r_rsp_valid <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            for (int i = 0; i < NUM_REQ; i++) r_req_ready[i] <= (w_gid == IDW'(i));
            r_id      <= w_gid;
            r_ptr     <= w_gid;
            r_addr    <= w_sel_addr;
            r_wdata   <= w_sel_wdata;
            r_wstrb   <= w_sel_wstrb;
            r_awvalid <= w_sel_write;
            r_wvalid  <= w_sel_write;
            r_arvalid <= !w_sel_write;
          end
        end
        S_WADDR: begin
          if (r_awvalid && M_AXI_AWREADY) r_awvalid <= 1'b0;
          if (r_wvalid && M_AXI_WREADY)   r_wvalid  <= 1'b0;
          if (w_aw_ok && w_w_ok)          r_bready  <= 1'b1;
        end
        S_WRESP: begin
          if (M_AXI_BVALID) begin
            r_bready   <= 1'b0;
            r_cap_data <= '0;
            r_cap_resp <= M_AXI_BRESP;
          end
        end
        S_RADDR: begin
          if (M_AXI_ARREADY) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
          end
        end
        S_RDATA: begin
          if (M_AXI_RVALID) begin
            r_rready   <= 1'b0;
            r_cap_data <= M_AXI_RDATA;
            r_cap_resp <= M_AXI_RRESP;
          end
        end
        S_RESP: begin
          for (int i = 0; i < NUM_REQ; i++) r_rsp_valid[i] <= (r_id == IDW'(i));
          r_rsp_rdata <= r_cap_data;
          r_rsp_resp  <= r_cap_resp;
        end
        default: ;
      endcase
    end
  end

  assign req_ready     = r_req_ready;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_rdata     = r_rsp_rdata;
  assign rsp_resp      = r_rsp_resp;
  assign M_AXI_AWADDR  = r_addr;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = r_awvalid;
  assign M_AXI_WDATA   = r_wdata;
  assign M_AXI_WSTRB   = r_wstrb;
  assign M_AXI_WVALID  = r_wvalid;
  assign M_AXI_BREADY  = r_bready;
  assign M_AXI_ARADDR  = r_addr;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = r_arvalid;
  assign M_AXI_RREADY  = r_rready;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_regbank_axil_arbiter.sv
// Directed bench for regbank_axil_arbiter with a small 4-register AXI4-Lite slave model
// whose AWREADY/WREADY delays and RRESP value are adjustable.
module tb_regbank_axil_arbiter;

  localparam int N  = 2;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int SW = 4;

  // Handshake: a requester raises req_valid[i] with its fields and holds them until it
  // sees req_ready[i]; rsp_valid[i] later pulses once with rsp_rdata/rsp_resp.
  // AXI channels follow VALID/READY: a transfer happens on a rising edge with both high.

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid = '0, req_write = '0;
  logic [N*AW-1:0] req_addr  = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N*SW-1:0] req_wstrb = '0;
  logic [N-1:0]    req_ready, rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic [1:0]      rsp_resp;
  logic [AW-1:0]   awaddr, araddr;
  logic [2:0]      awprot, arprot, dbg_state;
  logic            awvalid, awready, wvalid, wready, bready, arvalid, arready, rready;
  logic [DW-1:0]   wdata;
  logic [SW-1:0]   wstrb;
  logic [1:0]      bresp = 2'b00, rresp = 2'b00;
  logic            bvalid = 1'b0, rvalid = 1'b0;
  logic [DW-1:0]   rdata = '0;

  regbank_axil_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .ACLK(clk), .ARESET(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
    .o_dbg_state(dbg_state)
  );

  // ---------------- slave model ----------------
  int            aw_delay = 0, w_delay = 0, aw_wait = 0, w_wait = 0;
  logic [1:0]    rresp_cfg = 2'b00;
  logic [DW-1:0] mem [4];
  logic          got_aw = 1'b0, got_w = 1'b0, t_have_aw, t_have_w;
  logic [AW-1:0] s_awaddr = '0, t_addr;
  logic [DW-1:0] s_wdata = '0, t_wdata;
  logic [SW-1:0] s_wstrb = '0, t_wstrb;

  assign awready = awvalid && (aw_wait >= aw_delay);
  assign wready  = wvalid && (w_wait >= w_delay);
  assign arready = arvalid;

  always @(posedge clk) begin
    if (rst) begin
      bvalid <= 1'b0; rvalid <= 1'b0; got_aw <= 1'b0; got_w <= 1'b0;
      aw_wait <= 0; w_wait <= 0;
      for (int i = 0; i < 4; i++) mem[i] <= '0;
    end else begin
      aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
      w_wait  <= (wvalid && !wready) ? w_wait + 1 : 0;
      if (awvalid && awready) s_awaddr <= awaddr;
      if (wvalid && wready) begin s_wdata <= wdata; s_wstrb <= wstrb; end
      t_have_aw = got_aw || (awvalid && awready);
      t_have_w  = got_w || (wvalid && wready);
      t_addr    = (awvalid && awready) ? awaddr : s_awaddr;
      t_wdata   = (wvalid && wready) ? wdata : s_wdata;
      t_wstrb   = (wvalid && wready) ? wstrb : s_wstrb;
      if (bvalid && bready) bvalid <= 1'b0;
      if (t_have_aw && t_have_w) begin
        for (int b = 0; b < SW; b++)
          if (t_wstrb[b]) mem[t_addr[3:2]][b*8 +: 8] <= t_wdata[b*8 +: 8];
        bvalid <= 1'b1; bresp <= 2'b00;
        got_aw <= 1'b0; got_w <= 1'b0;
      end else begin
        got_aw <= t_have_aw; got_w <= t_have_w;
      end
      if (rvalid && rready) rvalid <= 1'b0;
      if (arvalid && arready) begin
        rvalid <= 1'b1; rdata <= mem[araddr[3:2]]; rresp <= rresp_cfg;
      end
    end
  end

  // ---------------- bus monitor ----------------
  int            aw_hs = 0, w_hs = 0, b_hs = 0, stab_viol = 0;
  logic          p_aw_pend = 1'b0, p_w_pend = 1'b0;
  logic [AW-1:0] p_awaddr = '0;
  logic [DW-1:0] p_wdata = '0;
  logic [N-1:0]  prev_valid = '0;

  always @(posedge clk) begin
    if (!rst) begin
      if (p_aw_pend && (!awvalid || awaddr != p_awaddr)) stab_viol++;
      if (p_w_pend && (!wvalid || wdata != p_wdata)) stab_viol++;
      if (awvalid && awready) aw_hs++;
      if (wvalid && wready) w_hs++;
      if (bvalid && bready) b_hs++;
    end
    p_aw_pend = !rst && awvalid && !awready;
    p_w_pend  = !rst && wvalid && !wready;
    p_awaddr  = awaddr;
    p_wdata   = wdata;
    for (int i = 0; i < N; i++)
      assert (rst || !(prev_valid[i] && !req_valid[i] && !req_ready[i]))
        else $error("request %0d withdrawn before req_ready", i);
    prev_valid <= req_valid;
  end

  // ---------------- scoreboard / checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_req(input int id, input logic wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] d, input logic [SW-1:0] strb);
    req_write[id]            = wr;
    req_addr[id*AW +: AW]    = addr;
    req_wdata[id*DW +: DW]   = d;
    req_wstrb[id*SW +: SW]   = strb;
    req_valid[id]            = 1'b1;
  endtask

  task automatic wait_grant(output int g, output int cyc);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (req_ready == '0 && cyc < 200);
    g = -1;
    for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
    check_eq("grant_onehot", 32'($countones(req_ready)), 32'd1);
  endtask

  task automatic txn(input int id, input logic wr, input logic [AW-1:0] addr,
                     input logic [DW-1:0] d, input logic [SW-1:0] strb,
                     output logic [DW-1:0] rd, output logic [1:0] rs, output int lat);
    int g, c;
    @(negedge clk);
    set_req(id, wr, addr, d, strb);
    wait_grant(g, c);
    check_eq("grant_id", 32'(g), 32'(id));
    req_valid[id] = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rsp_valid[id] && lat < 200);
    check_eq("rsp_onehot", 32'(rsp_valid), 32'(1 << id));
    rd = rsp_rdata;
    rs = rsp_resp;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] rd;
    logic [1:0]    rs;
    int            lat, g, c, a0, w0, b0, v0, quiet;
    int            exp_order [9] = '{0, 1, 0, 1, 0, 1, 0, 1, 0};

    do_reset();
    check_eq("rst_req_ready", 32'(req_ready), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_axi_flags", {27'd0, awvalid, wvalid, bready, arvalid, rready}, 32'd0);
    check_eq("rst_rdata", rsp_rdata, 32'd0);
    check_eq("rst_state", 32'(dbg_state), 32'd0);
    check_eq("rst_awaddr", 32'(awaddr), 32'd0);

    // 1: write then read back four registers on requester 0
    for (int i = 0; i < 4; i++) begin
      txn(0, 1'b1, AW'(i * 4), DW'(i + 1), 4'hF, rd, rs, lat);
      check_eq("t1_wr_lat", 32'(lat), 32'd3);
      check_eq("t1_wr_resp", 32'(rs), 32'd0);
      check_eq("t1_wr_rdata", rd, 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      txn(0, 1'b0, AW'(i * 4), '0, '0, rd, rs, lat);
      check_eq("t1_rd_lat", 32'(lat), 32'd3);
      check_eq("t1_rd_resp", 32'(rs), 32'd0);
      check_eq("t1_rd_data", rd, DW'(i + 1));
    end

    // 2: simultaneous requests straight after reset
    do_reset();
    set_req(0, 1'b1, 4'h0, 32'hA5A5A5A5, 4'hF);
    set_req(1, 1'b1, 4'h4, 32'h5A5A5A5A, 4'hF);
    wait_grant(g, c);
    check_eq("t2_first", 32'(g), 32'd0);
    if (g >= 0) req_valid[g] = 1'b0;
    wait_grant(g, c);
    check_eq("t2_second", 32'(g), 32'd1);
    check_eq("t2_b2b_gap", 32'(c), 32'd4);
    if (g >= 0) req_valid[g] = 1'b0;
    repeat (5) @(negedge clk);
    txn(0, 1'b0, 4'h0, '0, '0, rd, rs, lat);
    check_eq("t2_rd0", rd, 32'hA5A5A5A5);
    txn(1, 1'b0, 4'h4, '0, '0, rd, rs, lat);
    check_eq("t2_rd1", rd, 32'h5A5A5A5A);

    // 3: both requesters continuously valid -> strict alternation
    @(negedge clk);
    set_req(0, 1'b0, 4'h0, '0, '0);
    set_req(1, 1'b0, 4'h4, '0, '0);
    for (int k = 0; k < 9; k++) begin
      wait_grant(g, c);
      check_eq("t3_order", 32'(g), 32'(exp_order[k]));
      if (k > 0) check_eq("t3_gap", 32'(c), 32'd4);
      if (k >= 7 && g >= 0) req_valid[g] = 1'b0;
    end
    repeat (5) @(negedge clk);

    // 4: delayed AWREADY, then delayed WREADY, with partial strobes
    txn(0, 1'b1, 4'h8, 32'h12345678, 4'hF, rd, rs, lat);
    aw_delay = 3; w_delay = 0;
    a0 = aw_hs; w0 = w_hs; b0 = b_hs; v0 = stab_viol;
    txn(0, 1'b1, 4'h8, 32'hFFFFFFFF, 4'b0011, rd, rs, lat);
    check_eq("t4a_lat", 32'(lat), 32'd6);
    check_eq("t4a_resp", 32'(rs), 32'd0);
    check_eq("t4a_hs", 32'(aw_hs - a0) << 8 | 32'(w_hs - w0) << 4 | 32'(b_hs - b0), 32'h111);
    check_eq("t4a_stable", 32'(stab_viol - v0), 32'd0);
    aw_delay = 0;
    txn(1, 1'b0, 4'h8, '0, '0, rd, rs, lat);
    check_eq("t4a_rd", rd, 32'h1234FFFF);
    w_delay = 3;
    a0 = aw_hs; w0 = w_hs; b0 = b_hs; v0 = stab_viol;
    txn(0, 1'b1, 4'h8, 32'hABCD0000, 4'b1100, rd, rs, lat);
    check_eq("t4b_lat", 32'(lat), 32'd6);
    check_eq("t4b_hs", 32'(aw_hs - a0) << 8 | 32'(w_hs - w0) << 4 | 32'(b_hs - b0), 32'h111);
    check_eq("t4b_stable", 32'(stab_viol - v0), 32'd0);
    w_delay = 0;
    txn(1, 1'b0, 4'h8, '0, '0, rd, rs, lat);
    check_eq("t4b_rd", rd, 32'hABCDFFFF);

    // 5: error response passes through, next transfer is normal
    rresp_cfg = 2'b10;
    txn(0, 1'b0, 4'h0, '0, '0, rd, rs, lat);
    check_eq("t5_err_resp", 32'(rs), 32'd2);
    check_eq("t5_err_data", rd, 32'hA5A5A5A5);
    rresp_cfg = 2'b00;
    txn(1, 1'b0, 4'h8, '0, '0, rd, rs, lat);
    check_eq("t5_ok_resp", 32'(rs), 32'd0);
    check_eq("t5_ok_data", rd, 32'hABCDFFFF);
    check_eq("t5_ok_lat", 32'(lat), 32'd3);

    // 6: reset while waiting for the write response
    @(negedge clk);
    set_req(0, 1'b1, 4'h4, 32'h00000077, 4'hF);
    wait_grant(g, c);
    req_valid[0] = 1'b0;
    @(negedge clk);
    check_eq("t6_in_wresp", 32'(dbg_state), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    check_eq("t6_state", 32'(dbg_state), 32'd0);
    check_eq("t6_axi_flags", {27'd0, awvalid, wvalid, bready, arvalid, rready}, 32'd0);
    check_eq("t6_req_ready", 32'(req_ready), 32'd0);
    check_eq("t6_rsp_valid", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    quiet = 0;
    repeat (6) begin @(negedge clk); if (rsp_valid != '0) quiet++; end
    check_eq("t6_no_rsp", 32'(quiet), 32'd0);
    txn(1, 1'b1, 4'hC, 32'h0BADF00D, 4'hF, rd, rs, lat);
    check_eq("t6_wr_resp", 32'(rs), 32'd0);
    txn(1, 1'b0, 4'hC, '0, '0, rd, rs, lat);
    check_eq("t6_rd", rd, 32'h0BADF00D);
    check_eq("t6_rd_lat", 32'(lat), 32'd3);

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
